// File: rtl/id_branch_unit_pkg.sv
// Shared constants and types for the decode-stage branch unit.
package id_branch_unit_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    StRun,
    StRedirect
  } state_e;

endpackage

// File: rtl/id_branch_unit_if.sv
// Fetch <-> decode bundle: IF/ID inputs, register operands, redirect pair and IF/ID outputs.
interface id_branch_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);

  logic [DATA_W-1:0] pc4_if;
  logic [DATA_W-1:0] instr_if;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              pcsrc_if;
  logic [DATA_W-1:0] branch_target;
  logic [DATA_W-1:0] instr_id;
  logic [DATA_W-1:0] pc4_id;
  logic              valid_id;
  logic [CNT_W-1:0]  taken_count;

  modport master (
    output pc4_if, instr_if, rs_data, rt_data,
    input  pcsrc_if, branch_target, instr_id, pc4_id, valid_id, taken_count
  );

  modport slave (
    input  pc4_if, instr_if, rs_data, rt_data,
    output pcsrc_if, branch_target, instr_id, pc4_id, valid_id, taken_count
  );

endinterface

// File: rtl/id_branch_unit_branch_target_calc.sv
// Combinational branch/jump target and taken decision for the instruction held in IF/ID.
module id_branch_unit_branch_target_calc #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic              valid_i,
  output logic              take_o,
  output logic [DATA_W-1:0] target_o
);
  import id_branch_unit_pkg::*;

  logic [5:0]        opcode;
  logic              is_beq, is_bne, is_j;
  logic [DATA_W-1:0] br_offset;

  always_comb begin
    opcode    = instr_i[31:26];
    is_beq    = (opcode == OP_BEQ);
    is_bne    = (opcode == OP_BNE);
    is_j      = (opcode == OP_J);
    br_offset = {{(DATA_W - 18){instr_i[15]}}, instr_i[15:0], 2'b00};
    take_o    = valid_i & ((is_beq & (rs_i == rt_i)) | (is_bne & (rs_i != rt_i)) | is_j);
    if (is_j) begin
      target_o = {pc4_i[DATA_W-1:28], instr_i[25:0], 2'b00};
    end else begin
      target_o = pc4_i + br_offset;
    end
  end

endmodule

// File: rtl/id_branch_unit.sv
// IF/ID pipeline register with decode-stage branch resolution, redirect FSM and taken counter.
module id_branch_unit #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [DATA_W-1:0] NOP_INSTR = id_branch_unit_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  id_branch_unit_if.slave bus
);
  import id_branch_unit_pkg::*;

  state_e            state_q, state_d;
  logic              pcsrc_q, pcsrc_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              take;
  logic [DATA_W-1:0] calc_target;

  id_branch_unit_branch_target_calc #(
    .DATA_W (DATA_W)
  ) u_calc (
    .instr_i  (instr_q),
    .pc4_i    (pc4_q),
    .rs_i     (bus.rs_data),
    .rt_i     (bus.rt_data),
    .valid_i  (valid_q),
    .take_o   (take),
    .target_o (calc_target)
  );

  // Defaults describe a bubble; only a non-taken RUN cycle admits the fetched word.
  always_comb begin
    state_d  = StRun;
    pcsrc_d  = 1'b0;
    target_d = target_q;
    instr_d  = NOP_INSTR;
    pc4_d    = '0;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      StRun: begin
        if (take) begin
          state_d  = StRedirect;
          pcsrc_d  = 1'b1;
          target_d = calc_target;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          instr_d = bus.instr_if;
          pc4_d   = bus.pc4_if;
          valid_d = 1'b1;
        end
      end
      StRedirect: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      pcsrc_q  <= 1'b0;
      target_q <= '0;
      instr_q  <= NOP_INSTR;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pcsrc_q  <= pcsrc_d;
      target_q <= target_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.pcsrc_if      = pcsrc_q;
  assign bus.branch_target = target_q;
  assign bus.instr_id      = instr_q;
  assign bus.pc4_id        = pc4_q;
  assign bus.valid_id      = valid_q;
  assign bus.taken_count   = cnt_q;

endmodule

// File: tb/tb_id_branch_unit.sv
// Directed scoreboard bench: per-cycle expectations queued at stimulus, popped by a monitor.
module tb_id_branch_unit;

  localparam int unsigned M_PCSRC = 1;
  localparam int unsigned M_TGT   = 2;
  localparam int unsigned M_INSTR = 4;
  localparam int unsigned M_PC4   = 8;
  localparam int unsigned M_VALID = 16;
  localparam int unsigned M_CNT   = 32;
  localparam int unsigned M_SAT   = 64;
  localparam int unsigned M_ALL   = 127;
  localparam int unsigned M_BUB   = M_ALL & ~M_PC4;

  typedef struct {
    string       name;
    int unsigned mask;
    logic        pcsrc;
    logic [31:0] tgt;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] cnt;
    logic [3:0]  sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_t        sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  id_branch_unit_if #(.DATA_W(32), .CNT_W(16)) bus ();
  id_branch_unit_if #(.DATA_W(32), .CNT_W(4))  sat_bus ();

  // Narrow-counter instance sees identical traffic so saturation is reachable quickly.
  assign sat_bus.instr_if = bus.instr_if;
  assign sat_bus.pc4_if   = bus.pc4_if;
  assign sat_bus.rs_data  = bus.rs_data;
  assign sat_bus.rt_data  = bus.rt_data;

  id_branch_unit #(
    .DATA_W    (32),
    .CNT_W     (16),
    .NOP_INSTR (32'h0000_0000)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  id_branch_unit #(
    .DATA_W    (32),
    .CNT_W     (4),
    .NOP_INSTR (32'h0000_0000)
  ) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] pc4,
                       input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    rst          = r;
    bus.instr_if = ins;
    bus.pc4_if   = pc4;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
  endtask

  task automatic expect_v(input string name, input int unsigned mask, input logic pcsrc,
                          input logic [31:0] tgt, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid, input logic [15:0] cnt,
                          input logic [3:0] sat);
    exp_t e;
    e.name = name; e.mask = mask; e.pcsrc = pcsrc; e.tgt = tgt; e.instr = instr;
    e.pc4 = pc4; e.valid = valid; e.cnt = cnt; e.sat = sat;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if ((e.mask & M_PCSRC) != 0) chk(e.name, "pcsrc_if", {31'd0, bus.pcsrc_if}, {31'd0, e.pcsrc});
        if ((e.mask & M_TGT) != 0)   chk(e.name, "branch_target", bus.branch_target, e.tgt);
        if ((e.mask & M_INSTR) != 0) chk(e.name, "instr_id", bus.instr_id, e.instr);
        if ((e.mask & M_PC4) != 0)   chk(e.name, "pc4_id", bus.pc4_id, e.pc4);
        if ((e.mask & M_VALID) != 0) chk(e.name, "valid_id", {31'd0, bus.valid_id}, {31'd0, e.valid});
        if ((e.mask & M_CNT) != 0)   chk(e.name, "taken_count", {16'd0, bus.taken_count}, {16'd0, e.cnt});
        if ((e.mask & M_SAT) != 0)   chk(e.name, "taken_count_w4", {28'd0, sat_bus.taken_count}, {28'd0, e.sat});
      end
    end
  end

  initial begin : stimulus
    logic [31:0] pc4, tgt, prev_tgt;
    logic [15:0] k;
    logic [3:0]  s0, s1;
    bus.instr_if = '0; bus.pc4_if = '0; bus.rs_data = '0; bus.rt_data = '0;

    drive(1, 32'h0, 32'h0, 0, 0);
    expect_v("reset", M_ALL, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

    // BEQ taken: target 0x10 + (3 << 2)
    drive(0, 32'h1022_0003, 32'h10, 0, 0);
    expect_v("beq_load", M_ALL, 0, 32'h0, 32'h1022_0003, 32'h10, 1, 0, 0);
    drive(0, 32'h0000_0001, 32'h14, 5, 5);
    expect_v("beq_taken", M_BUB, 1, 32'h1C, 32'h0, 32'h0, 0, 1, 1);
    drive(0, 32'h0000_0002, 32'h18, 5, 5);
    expect_v("beq_redir", M_BUB, 0, 32'h1C, 32'h0, 32'h0, 0, 1, 1);
    drive(0, 32'h0022_1820, 32'h20, 0, 0);
    expect_v("beq_target", M_ALL, 0, 32'h1C, 32'h0022_1820, 32'h20, 1, 1, 1);

    // BNE backward: 0x20 - 8
    drive(0, 32'h1422_FFFE, 32'h20, 0, 0);
    expect_v("bne_load", M_ALL, 0, 32'h1C, 32'h1422_FFFE, 32'h20, 1, 1, 1);
    drive(0, 32'h0000_0003, 32'h24, 1, 2);
    expect_v("bne_taken", M_BUB, 1, 32'h18, 32'h0, 32'h0, 0, 2, 2);
    drive(0, 32'h0000_0004, 32'h28, 1, 2);
    expect_v("bne_redir", M_BUB, 0, 32'h18, 32'h0, 32'h0, 0, 2, 2);

    // BEQ not taken, ALU op follows with zero penalty
    drive(0, 32'h1022_0003, 32'h1C, 0, 0);
    expect_v("beqnt_load", M_ALL, 0, 32'h18, 32'h1022_0003, 32'h1C, 1, 2, 2);
    drive(0, 32'h0022_1820, 32'h20, 1, 2);
    expect_v("beqnt_alu", M_ALL, 0, 32'h18, 32'h0022_1820, 32'h20, 1, 2, 2);

    // J with BEQs fetched into both squash slots
    drive(0, 32'h0800_0040, 32'h30, 0, 0);
    expect_v("j_load", M_ALL, 0, 32'h18, 32'h0800_0040, 32'h30, 1, 2, 2);
    drive(0, 32'h1022_0003, 32'h34, 7, 7);
    expect_v("j_taken", M_BUB, 1, 32'h100, 32'h0, 32'h0, 0, 3, 3);
    drive(0, 32'h1022_0003, 32'h38, 7, 7);
    expect_v("j_redir", M_BUB, 0, 32'h100, 32'h0, 32'h0, 0, 3, 3);
    drive(0, 32'h0022_1820, 32'h104, 7, 7);
    expect_v("j_squash_beq", M_ALL, 0, 32'h100, 32'h0022_1820, 32'h104, 1, 3, 3);

    // Reset asserted during the redirect cycle
    drive(0, 32'h0800_0040, 32'h200, 0, 0);
    expect_v("rj_load", M_ALL, 0, 32'h100, 32'h0800_0040, 32'h200, 1, 3, 3);
    drive(0, 32'h0, 32'h204, 0, 0);
    expect_v("rj_taken", M_BUB, 1, 32'h100, 32'h0, 32'h0, 0, 4, 4);
    drive(1, 32'h0, 32'h208, 0, 0);
    expect_v("rst_mid_redirect", M_ALL, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    drive(0, 32'h0022_1820, 32'h44, 0, 0);
    expect_v("rst_run", M_ALL, 0, 32'h0, 32'h0022_1820, 32'h44, 1, 0, 0);

    // Repeated jumps: the 4-bit counter must stick at 15
    prev_tgt = 32'h0;
    for (int i = 0; i < 20; i++) begin
      pc4 = (i == 0) ? 32'hF000_0030 : 32'h30;
      tgt = (i == 0) ? 32'hF000_0100 : 32'h100;
      k   = 16'(i);
      s0  = (i > 15) ? 4'd15 : 4'(i);
      s1  = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      drive(0, 32'h0800_0040, pc4, 0, 0);
      expect_v("sat_load", M_ALL, 0, prev_tgt, 32'h0800_0040, pc4, 1, k, s0);
      drive(0, 32'h0, pc4 + 4, 0, 0);
      expect_v("sat_taken", M_BUB, 1, tgt, 32'h0, 32'h0, 0, k + 16'd1, s1);
      drive(0, 32'h0, pc4 + 8, 0, 0);
      expect_v("sat_redir", M_BUB, 0, tgt, 32'h0, 32'h0, 0, k + 16'd1, s1);
      prev_tgt = tgt;
    end
    drive(0, 32'h0022_1820, 32'h40, 0, 0);
    expect_v("sat_hold", M_ALL, 0, 32'h100, 32'h0022_1820, 32'h40, 1, 20, 15);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
